// File: rtl/rptr_empty_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : async_fifo_pkg
// Description : Shared async-FIFO helpers: pointer-width helper and
//               Gray/binary conversions on zero-extended values.
// Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

    localparam int GRAY_MAX_W       = 32;
    localparam int ADDRSIZE_DEFAULT = 4;
    localparam int PTR_W_DEFAULT    = ADDRSIZE_DEFAULT + 1;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_w(input int addrsize);
        return addrsize + 1;
    endfunction

    // Both conversions are width-agnostic when the operand is zero-extended,
    // so callers pass any width up to GRAY_MAX_W and slice the result.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : async_fifo_pkg
`default_nettype wire

// File: rtl/rptr_empty_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : rptr_empty_ctrl_if
// Description : Read-side FIFO bundle between the reader and the read-pointer
//               controller. arempty exists only with RPTR_AEMPTY_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rptr_empty_ctrl_if #(
    parameter int ADDRSIZE = 4
);
    import async_fifo_pkg::*;

    localparam int PW = ptr_w(ADDRSIZE);

    logic                rinc;
    logic [PW-1:0]       rq2_wptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [PW-1:0]       rptr;
    logic                rempty;
    logic [PW-1:0]       rlevel;
`ifdef RPTR_AEMPTY_EN
    logic                arempty;
`endif

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, rlevel
`ifdef RPTR_AEMPTY_EN
        , input arempty
`endif
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, rlevel
`ifdef RPTR_AEMPTY_EN
        , output arempty
`endif
    );

endinterface : rptr_empty_ctrl_if
`default_nettype wire

// File: rtl/rptr_empty_ctrl_gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin_conv
// Description : Combinational Gray-to-binary converter (XOR prefix from MSB).
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = PTR_W_DEFAULT
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule : gray2bin_conv
`default_nettype wire

// File: rtl/rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_ctrl
// Description : Read-domain pointer, empty flag and fill-level controller for
//               the async FIFO. Optional almost-empty flag: RPTR_AEMPTY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    rptr_empty_ctrl_if.slave rif
);

    localparam int PW = ptr_w(ADDRSIZE);

    logic [PW-1:0] rbin_q,   rbin_d;
    logic [PW-1:0] rptr_q,   rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          w_rpop;
    logic [PW-1:0] w_wbin;
`ifdef RPTR_AEMPTY_EN
    logic          arempty_q, arempty_d;
`endif

    gray2bin_conv #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .i_gray (rif.rq2_wptr),
        .o_bin  (w_wbin)
    );

    // Flags are computed from the post-pop pointer so the last pop raises
    // empty on the very next edge.
    always_comb begin
        w_rpop   = rif.rinc & ~rempty_q;
        rbin_d   = rbin_q + {{(PW-1){1'b0}}, w_rpop};
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        rempty_d = (rptr_d == rif.rq2_wptr);
        rlevel_d = w_wbin - rbin_d;
`ifdef RPTR_AEMPTY_EN
        arempty_d = (rlevel_d <= PW'(AEMPTY_THRESH));
`endif
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            rlevel_q <= rlevel_d;
        end
    end

`ifdef RPTR_AEMPTY_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            arempty_q <= 1'b1;
        end else begin
            arempty_q <= arempty_d;
        end
    end

    assign rif.arempty = arempty_q;
`endif

    assign rif.raddr  = rbin_q[ADDRSIZE-1:0];
    assign rif.rptr   = rptr_q;
    assign rif.rempty = rempty_q;
    assign rif.rlevel = rlevel_q;

    a_rptr_gray_step: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        $onehot0(rptr_q ^ $past(rptr_q))
    );

    a_no_advance_when_empty: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        rempty_q |=> (rbin_q[ADDRSIZE-1:0] == $past(rbin_q[ADDRSIZE-1:0]))
    );

endmodule : rptr_empty_ctrl
`default_nettype wire

// File: tb/tb_rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rptr_empty_ctrl
// Description : Self-checking bench for rptr_empty_ctrl: count-based reader
//               model plus directed literal checks. Honours RPTR_AEMPTY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_ctrl;

    localparam int AW     = 4;
    localparam int PW     = AW + 1;
    localparam int DEPTH  = 16;
    localparam int MODV   = 32;
    localparam int THRESH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wcnt   = 0;
    int   m_rcnt = 0;
    int   m_wseen = 0;
    logic model_on = 1'b0;

    rptr_empty_ctrl_if #(.ADDRSIZE(AW)) rif ();

    rptr_empty_ctrl #(
        .ADDRSIZE      (AW),
        .AEMPTY_THRESH (THRESH)
    ) dut (
        .rclk   (clk),
        .rrst_n (rst_n),
        .rif    (rif.slave)
    );

    always #5 clk = ~clk;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Entries visible to the reader: writes seen minus reads done, mod 2^(AW+1).
    function automatic int mlevel();
        return (((m_wseen - m_rcnt) % MODV) + MODV) % MODV;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reader model: counts pops and the write count seen at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rcnt  <= 0;
            m_wseen <= 0;
        end else begin
            if (rif.rinc && mlevel() != 0) m_rcnt <= m_rcnt + 1;
            m_wseen <= wcnt;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_rempty", 32'(rif.rempty), 32'(mlevel() == 0));
            chk("model_rlevel", 32'(rif.rlevel), 32'(mlevel()));
            chk("model_rptr",   32'(rif.rptr),   32'(gray(m_rcnt % MODV)));
            chk("model_raddr",  32'(rif.raddr),  32'(m_rcnt % DEPTH));
`ifdef RPTR_AEMPTY_EN
            chk("model_arempty", 32'(rif.arempty), 32'(mlevel() <= THRESH));
`endif
        end
    end

    task automatic setw(input int n);
        wcnt         = n;
        rif.rq2_wptr = PW'(gray(n % MODV));
    endtask

    task automatic step(input logic inc);
        rif.rinc = inc;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rempty"}, 32'(rif.rempty), 32'd1);
        chk({tag, "_rptr"},   32'(rif.rptr),   32'd0);
        chk({tag, "_raddr"},  32'(rif.raddr),  32'd0);
        chk({tag, "_rlevel"}, 32'(rif.rlevel), 32'd0);
`ifdef RPTR_AEMPTY_EN
        chk({tag, "_arempty"}, 32'(rif.arempty), 32'd1);
`endif
    endtask

    int aexp [0:4] = '{1, 1, 1, 0, 0};

    initial begin
        rif.rinc = 1'b0;
        setw(0);
        #1 rst_n = 1'b0;
        model_on = 1'b1;
        #2;
        chk_reset_vals("por");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Fill to 5 then drain
        setw(5);
        step(1'b0);
        chk("fill_rlevel", 32'(rif.rlevel), 32'd5);
        chk("fill_rempty", 32'(rif.rempty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("drain_rlevel", 32'(rif.rlevel), 32'(4 - i));
            chk("drain_raddr",  32'(rif.raddr),  32'(i + 1));
            chk("drain_rempty", 32'(rif.rempty), 32'(i == 4));
        end

        // Underflow: rinc held while empty
        repeat (10) step(1'b1);
        chk("uflow_raddr",  32'(rif.raddr),  32'd5);
        chk("uflow_rptr",   32'(rif.rptr),   32'd7);
        chk("uflow_rlevel", 32'(rif.rlevel), 32'd0);

        // Push/pop pairs up to rbin = 31
        for (int k = 6; k < 32; k++) begin
            setw(k);
            step(1'b0);
            step(1'b1);
        end
        chk("prewrap_rptr",   32'(rif.rptr),   32'd16);
        chk("prewrap_rempty", 32'(rif.rempty), 32'd1);
        setw(32);
        step(1'b0);
        chk("wrap_avail_rlevel", 32'(rif.rlevel), 32'd1);
        chk("wrap_avail_rptr",   32'(rif.rptr),   32'b10000);
        step(1'b1);
        chk("wrap_rptr",   32'(rif.rptr),   32'b00000);
        chk("wrap_raddr",  32'(rif.raddr),  32'd0);
        chk("wrap_rempty", 32'(rif.rempty), 32'd1);

        // Full level with rbin = 0
        setw(48);
        step(1'b0);
        chk("full_rlevel", 32'(rif.rlevel), 32'd16);
        chk("full_rempty", 32'(rif.rempty), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1);
            chk("drain16_rlevel", 32'(rif.rlevel), 32'(15 - i));
`ifdef RPTR_AEMPTY_EN
            if (15 - i <= 4) chk("aempty_lit", 32'(rif.arempty), 32'(aexp[15 - i]));
`endif
        end

        // Mid-run reset with rinc asserted
        setw(52);
        step(1'b1);
        step(1'b1);
        chk("prerst_rlevel", 32'(rif.rlevel), 32'd3);
        rst_n = 1'b0;
        setw(0);
        #1;
        chk_reset_vals("midrst");
        step(1'b1);
        step(1'b1);
        chk_reset_vals("inrst");
        rst_n = 1'b1;
        repeat (3) step(1'b1);
        chk_reset_vals("postrst");

        // Pop coinciding with a write-pointer update
        setw(3);
        step(1'b0);
        setw(5);
        step(1'b1);
        chk("simul_rlevel", 32'(rif.rlevel), 32'd4);
        chk("simul_raddr",  32'(rif.raddr),  32'd1);
        step(1'b0);

        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rptr_empty_ctrl
`default_nettype wire
